pixel_dispatcher: RTL

PIXEL_DISPATCHER -- requirements
Module: pixel_dispatcher

---
 rtl/pixel_dispatcher_if.sv | 32 +++
 rtl/pixel_dispatcher.sv | 115 +++++++++++
 2 files changed

// File: rtl/pixel_dispatcher_if.sv
// Handshake bundle between the frame controller/worker side and the pixel
// dispatcher. The abort signal exists only when DISPATCH_ABORT_EN is defined.
interface pixel_dispatcher_if;
  logic       frame_start;
  logic       JW_ready;
  logic       JW_start;
  logic [9:0] pix_x;
  logic [9:0] pix_y;
  logic       frame_busy;
  logic       frame_done;
`ifdef DISPATCH_ABORT_EN
  logic       abort;

  modport master (
    output frame_start, JW_ready, abort,
    input  JW_start, pix_x, pix_y, frame_busy, frame_done
  );
  modport slave (
    input  frame_start, JW_ready, abort,
    output JW_start, pix_x, pix_y, frame_busy, frame_done
  );
`else
  modport master (
    output frame_start, JW_ready,
    input  JW_start, pix_x, pix_y, frame_busy, frame_done
  );
  modport slave (
    input  frame_start, JW_ready,
    output JW_start, pix_x, pix_y, frame_busy, frame_done
  );
`endif
endinterface

// File: rtl/pixel_dispatcher.sv
// Pixel dispatcher: walks an H_RES x V_RES frame in raster order and hands
// one pixel job at a time to a single worker over a ready/start handshake.
// A job is accepted when the worker drops JW_ready; the frame completes once
// the worker raises JW_ready again after the last job.
// Optional feature: define DISPATCH_ABORT_EN to add a synchronous frame abort.
module pixel_dispatcher #(
  parameter int H_RES = 320,
  parameter int V_RES = 240
) (
  input logic              clk,
  input logic              n_rst,
  pixel_dispatcher_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE, WAIT_RDY, ISSUE, WAIT_ACK, DRAIN, DONE
  } state_t;

  localparam logic [9:0] X_LAST = 10'(H_RES - 1);
  localparam logic [9:0] Y_LAST = 10'(V_RES - 1);

  state_t     state, state_nxt;
  logic [9:0] x_q, y_q;
  logic       start_q, busy_q, done_q;
  logic       load, advance, last_job, abort_req;

  assign last_job = (x_q == X_LAST) && (y_q == Y_LAST);

`ifdef DISPATCH_ABORT_EN
  assign abort_req = bus.abort && (state != IDLE);
`else
  assign abort_req = 1'b0;
`endif

  // Next-state decode; abort overrides every other transition.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    advance   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.frame_start) begin
          state_nxt = WAIT_RDY;
          load      = 1'b1;
        end
      end
      WAIT_RDY: if (bus.JW_ready) state_nxt = ISSUE;
      ISSUE:    state_nxt = WAIT_ACK;
      WAIT_ACK: begin
        // Falling JW_ready is the worker taking the job.
        if (!bus.JW_ready) begin
          if (last_job) begin
            state_nxt = DRAIN;
          end else begin
            state_nxt = WAIT_RDY;
            advance   = 1'b1;
          end
        end
      end
      DRAIN:    if (bus.JW_ready) state_nxt = DONE;
      DONE:     state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
    if (abort_req) begin
      state_nxt = IDLE;
      load      = 1'b0;
      advance   = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= IDLE;
    else        state <= state_nxt;
  end

  // Raster coordinate counter; held steady while a job is outstanding.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      x_q <= '0;
      y_q <= '0;
    end else if (load) begin
      x_q <= '0;
      y_q <= '0;
    end else if (advance) begin
      if (x_q == X_LAST) begin
        x_q <= '0;
        y_q <= y_q + 10'd1;
      end else begin
        x_q <= x_q + 10'd1;
      end
    end
  end

  // Status outputs registered from the next state so they line up with it.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      start_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      start_q <= (state_nxt == ISSUE);
      busy_q  <= (state_nxt == WAIT_RDY) || (state_nxt == ISSUE) ||
                 (state_nxt == WAIT_ACK) || (state_nxt == DRAIN);
      done_q  <= (state_nxt == DONE);
    end
  end

  assign bus.JW_start   = start_q;
  assign bus.pix_x      = x_q;
  assign bus.pix_y      = y_q;
  assign bus.frame_busy = busy_q;
  assign bus.frame_done = done_q;

endmodule
